// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_port_arbiter: round-robin share of one data-memory port by two masters
// Revision: 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int XLEN      = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [2:0]      m0_attr,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [2:0]      m1_attr,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [2:0]      mem_attr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err
);

    localparam int                 c_CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTST);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic                 r_prio;
    logic [MAX_OUTST-1:0] r_ids;
    logic [MAX_OUTST-1:0] w_ids_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [c_CNT_W-1:0]   w_wr_idx;
    logic                 w_full;
    logic                 w_sel;
    logic                 w_accept;
    logic                 w_pop;

    // w_sel: 0 selects m0, 1 selects m1
    assign w_sel    = (m0_req & m1_req) ? r_prio : m1_req;
    assign w_full   = (r_count == c_MAX_CNT);
    assign mem_req  = (m0_req | m1_req) & ~w_full & ~rst;
    assign w_accept = mem_req & mem_ready;
    assign m0_gnt   = w_accept & ~w_sel;
    assign m1_gnt   = w_accept &  w_sel;

    always_comb begin
        mem_we    = 1'b0;
        mem_attr  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (w_sel) begin
                mem_we    = m1_we;
                mem_attr  = m1_attr;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
            end else begin
                mem_we    = m0_we;
                mem_attr  = m0_attr;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
            end
        end
    end

    // Responses with nothing outstanding are dropped without touching state
    assign w_pop     = mem_rvalid & (r_count != '0) & ~rst;
    assign m0_rvalid = w_pop & ~r_ids[0];
    assign m1_rvalid = w_pop &  r_ids[0];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign m0_err    = mem_err;
    assign m1_err    = mem_err;

    // Head of the ID FIFO sits at bit 0; a pop shifts everything down one slot
    always_comb begin
        w_wr_idx  = w_pop ? (r_count - c_ONE) : r_count;
        w_ids_nxt = w_pop ? (r_ids >> 1) : r_ids;
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (w_accept && (c_CNT_W'(i) == w_wr_idx)) begin
                w_ids_nxt[i] = w_sel;
            end
        end
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_ids   <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_prio <= ~w_sel;
            end
            r_ids   <= w_ids_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_arbiter: directed self-checking bench for dmem_port_arbiter
// Revision: 1.0
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [2:0]      m0_attr;
    logic [XLEN-1:0] m0_addr, m0_wdata, m0_rdata;
    logic            m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [2:0]      m1_attr;
    logic [XLEN-1:0] m1_addr, m1_wdata, m1_rdata;
    logic            mem_req, mem_we, mem_ready, mem_rvalid, mem_err;
    logic [2:0]      mem_attr;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    dmem_port_arbiter #(.XLEN(XLEN), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_attr(m0_attr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_attr(m1_attr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_attr(mem_attr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs settle later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_attr = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_attr = 0; m1_addr = 0; m1_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        tick();

        // Reset holds everything off even with a live request
        m0_req = 1; m0_addr = 32'h40; m0_attr = 3'b101; mem_ready = 1;
        #2;
        chk("rst_m0_gnt",   m0_gnt,   0);
        chk("rst_mem_req",  mem_req,  0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_attr", mem_attr, 0);
        tick();
        rst = 1'b0;
        #2;
        chk("post_rst_m0_gnt", m0_gnt,   1);
        chk("post_rst_addr",   mem_addr, 32'h40);
        chk("post_rst_attr",   mem_attr, 3'b101);
        tick();
        m0_req = 0; mem_rvalid = 1; mem_rdata = 32'h11;
        #2;
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata",  m0_rdata,  32'h11);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        tick();

        // m1 store passes through exactly; error response routed to m1
        mem_rvalid = 0;
        m1_req = 1; m1_we = 1; m1_attr = 3'b010; m1_addr = 32'h100; m1_wdata = 32'hDEADBEEF;
        #2;
        chk("st_m1_gnt",   m1_gnt,    1);
        chk("st_m0_gnt",   m0_gnt,    0);
        chk("st_mem_req",  mem_req,   1);
        chk("st_mem_we",   mem_we,    1);
        chk("st_mem_attr", mem_attr,  3'b010);
        chk("st_mem_addr", mem_addr,  32'h100);
        chk("st_mem_wdat", mem_wdata, 32'hDEADBEEF);
        tick();
        m1_req = 0; m1_we = 0; mem_rvalid = 1; mem_err = 1; mem_rdata = 0;
        #2;
        chk("st_m1_rvalid", m1_rvalid, 1);
        chk("st_m1_err",    m1_err,    1);
        chk("st_m0_rvalid", m0_rvalid, 0);
        chk("idle_mem_req", mem_req,   0);
        chk("idle_mem_adr", mem_addr,  0);
        tick();

        // Both requesting: alternate grants, responses one cycle later
        mem_rvalid = 0; mem_err = 0;
        m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_addr = 32'h300;
        #2;
        chk("rr1_m0_gnt", m0_gnt, 1);
        chk("rr1_m1_gnt", m1_gnt, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hA0;
        #2;
        chk("rr2_m1_gnt",    m1_gnt,    1);
        chk("rr2_mem_addr",  mem_addr,  32'h300);
        chk("rr2_m0_rvalid", m0_rvalid, 1);
        chk("rr2_m0_rdata",  m0_rdata,  32'hA0);
        chk("rr2_m1_rvalid", m1_rvalid, 0);
        tick();
        mem_rdata = 32'hB1;
        #2;
        chk("rr3_m0_gnt",    m0_gnt,    1);
        chk("rr3_m1_rvalid", m1_rvalid, 1);
        chk("rr3_m1_rdata",  m1_rdata,  32'hB1);
        chk("rr3_m0_rvalid", m0_rvalid, 0);
        tick();
        m0_req = 0; mem_rdata = 32'hA2;
        #2;
        chk("rr4_m1_gnt",    m1_gnt,    1);
        chk("rr4_m0_rvalid", m0_rvalid, 1);
        chk("rr4_m0_rdata",  m0_rdata,  32'hA2);
        tick();
        m1_req = 0; mem_rdata = 32'hB3;
        #2;
        chk("rr5_m1_rvalid", m1_rvalid, 1);
        chk("rr5_m0_rvalid", m0_rvalid, 0);
        chk("rr5_m1_rdata",  m1_rdata,  32'hB3);
        tick();

        // Stall: no grants, priority holds (owner m0, then owner m1)
        mem_rvalid = 0; mem_ready = 0; m0_req = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("stall_a_gnt", {m0_gnt, m1_gnt}, 2'b00);
            tick();
        end
        mem_ready = 1;
        #2;
        chk("stall_a_m0_gnt", m0_gnt, 1);
        chk("stall_a_m1_gnt", m1_gnt, 0);
        tick();
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("stall_b_gnt", {m0_gnt, m1_gnt}, 2'b00);
            tick();
        end
        mem_ready = 1;
        #2;
        chk("stall_b_m1_gnt", m1_gnt, 1);
        chk("stall_b_m0_gnt", m0_gnt, 0);
        tick();

        // Two outstanding: third request blocked, even on the popping cycle
        m1_req = 0;
        #2;
        chk("full_mem_req",  mem_req,  0);
        chk("full_m0_gnt",   m0_gnt,   0);
        chk("full_mem_addr", mem_addr, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hC0;
        #2;
        chk("full_pop_mem_req", mem_req,   0);
        chk("full_pop_m0_gnt",  m0_gnt,    0);
        chk("full_pop_m0_rv",   m0_rvalid, 1);
        tick();
        mem_rvalid = 0;
        #2;
        chk("resume_m0_gnt", m0_gnt, 1);
        tick();

        // Reset with two outstanding (IDs m1, m0) and priority at m1
        rst = 1; mem_rvalid = 1; mem_rdata = 32'hEE;
        #2;
        chk("rst2_mem_req", mem_req,              0);
        chk("rst2_rvalid",  {m0_rvalid, m1_rvalid}, 2'b00);
        chk("rst2_gnt",     {m0_gnt, m1_gnt},     2'b00);
        tick();
        rst = 0; m0_req = 0;
        #2;
        chk("stray_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        tick();
        mem_rvalid = 0; m0_req = 1; m1_req = 1;
        #2;
        chk("rst2_prio_m0_gnt", m0_gnt, 1);
        chk("rst2_prio_m1_gnt", m1_gnt, 0);
        tick();
        m0_req = 0;
        #2;
        chk("rst2_m1_gnt", m1_gnt, 1);
        tick();
        m0_req = 1; m1_req = 0;
        #2;
        chk("rst2_full_req", mem_req, 0);
        tick();
        m0_req = 0; mem_rvalid = 1; mem_rdata = 32'h5A;
        #2;
        chk("rst2_resp0", {m0_rvalid, m1_rvalid}, 2'b10);
        tick();
        mem_rdata = 32'h5B;
        #2;
        chk("rst2_resp1",  {m0_rvalid, m1_rvalid}, 2'b01);
        chk("rst2_rdata1", m1_rdata, 32'h5B);
        tick();
        mem_rvalid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
